synaptic_update_engine: RTL

// - Autonomous FF-STDP weight-update sweep over the synaptic SRAM at end of a training sample.
// - Walks every pre-neuron row, read-modify-writes POST_NEUR_PARALLEL packed weights per word, one lane update per weight.
// - Sits between controller, neuron spike-count memories and the external single-port synaptic SRAM.
// - Muxes host/controller SRAM access through to the SRAM while idle.

---
 rtl/ffstdp_pkg.sv | 35 +++
 rtl/ffstdp_lane.sv | 30 +++
 rtl/synaptic_update_engine.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ffstdp_pkg.sv
// Shared state encoding, lane widths and weight saturation for the FF-STDP sweep.
package ffstdp_pkg;

  localparam int WEIGHT_WIDTH              = 8;
  localparam int PRE_NEUR_DATA_WIDTH       = 8;
  localparam int POST_NEUR_SPIKE_CNT_WIDTH = 7;
  localparam int LANE_DELTA_W              = PRE_NEUR_DATA_WIDTH + POST_NEUR_SPIKE_CNT_WIDTH;
  // Two guard bits: one for the weight sign, one for add/subtract overflow.
  localparam int LANE_SUM_W                = LANE_DELTA_W + 2;

  localparam logic signed [LANE_SUM_W-1:0] W_MAX = LANE_SUM_W'((2 ** (WEIGHT_WIDTH - 1)) - 1);
  localparam logic signed [LANE_SUM_W-1:0] W_MIN = LANE_SUM_W'(-(2 ** (WEIGHT_WIDTH - 1)));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_FETCH,
    ST_PRE_CHK,
    ST_RD,
    ST_WR,
    ST_FIN
  } sweep_state_e;

  function automatic logic [WEIGHT_WIDTH-1:0] satWeight(input logic signed [LANE_SUM_W-1:0] value);
    logic [WEIGHT_WIDTH-1:0] result;
    if (value > W_MAX) begin
      result = W_MAX[WEIGHT_WIDTH-1:0];
    end else if (value < W_MIN) begin
      result = W_MIN[WEIGHT_WIDTH-1:0];
    end else begin
      result = value[WEIGHT_WIDTH-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/ffstdp_lane.sv
// Single-weight FF-STDP update: w +/- (pre*post >> LR_SHIFT), saturated to the signed weight range.
module ffstdp_lane
  import ffstdp_pkg::*;
#(
  parameter int LR_SHIFT = 6
) (
  input  logic [WEIGHT_WIDTH-1:0]              weight_i,
  input  logic [POST_NEUR_SPIKE_CNT_WIDTH-1:0] post_cnt_i,
  input  logic [PRE_NEUR_DATA_WIDTH-1:0]       pre_cnt_i,
  input  logic                                 is_pos_i,
  output logic [WEIGHT_WIDTH-1:0]              weight_o
);

  logic        [LANE_DELTA_W-1:0] product;
  logic        [LANE_DELTA_W-1:0] delta;
  logic signed [LANE_SUM_W-1:0]   weightExt;
  logic signed [LANE_SUM_W-1:0]   deltaExt;
  logic signed [LANE_SUM_W-1:0]   sum;

  // Counts are unsigned; the product is kept full width before the learning-rate shift.
  always_comb begin
    product   = LANE_DELTA_W'(pre_cnt_i) * LANE_DELTA_W'(post_cnt_i);
    delta     = product >> LR_SHIFT;
    weightExt = {{(LANE_SUM_W - WEIGHT_WIDTH){weight_i[WEIGHT_WIDTH-1]}}, weight_i};
    deltaExt  = {{(LANE_SUM_W - LANE_DELTA_W){1'b0}}, delta};
    sum       = is_pos_i ? (weightExt + deltaExt) : (weightExt - deltaExt);
    weight_o  = satWeight(sum);
  end

endmodule

// File: rtl/synaptic_update_engine.sv
// End-of-sample FF-STDP sweep over the synaptic SRAM; passes host accesses through while idle.
// Build option: define SYN_ROW_SKIP_EN to skip rows whose pre-neuron spike count is zero.
module synaptic_update_engine
  import ffstdp_pkg::*;
#(
  parameter int INPUT_NEURON              = 784,
  parameter int ROW_WORDS                 = 64,
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int SYN_ARRAY_ADDR_WIDTH      = 16,
  parameter int PRE_NEUR_ADDR_WIDTH       = 10,
  parameter int POST_NEUR_WORD_ADDR_WIDTH = 8,
  parameter int LR_SHIFT                  = 6
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic                                                   start_i,
  input  logic                                                   is_pos_i,
  input  logic                                                   is_train_i,
  output logic                                                   busy_o,
  output logic                                                   done_o,
  input  logic                                                   host_cs_i,
  input  logic                                                   host_we_i,
  input  logic [SYN_ARRAY_ADDR_WIDTH-1:0]                        host_addr_i,
  input  logic [POST_NEUR_PARALLEL*WEIGHT_WIDTH-1:0]             host_wdata_i,
  output logic                                                   synarray_cs_o,
  output logic                                                   synarray_we_o,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0]                        synarray_addr_o,
  output logic [POST_NEUR_PARALLEL*WEIGHT_WIDTH-1:0]             synarray_wdata_o,
  input  logic [POST_NEUR_PARALLEL*WEIGHT_WIDTH-1:0]             synarray_rdata_i,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]                         pre_neur_addr_o,
  input  logic [PRE_NEUR_DATA_WIDTH-1:0]                         pre_neur_s_cnt_i,
  output logic [POST_NEUR_WORD_ADDR_WIDTH-1:0]                   post_neur_word_addr_o,
  input  logic [POST_NEUR_PARALLEL*POST_NEUR_SPIKE_CNT_WIDTH-1:0] post_neur_s_cnt_i
);

  localparam int WORD_W = POST_NEUR_PARALLEL * WEIGHT_WIDTH;

  sweep_state_e                             state_q, state_d;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]           row_q, row_d;
  logic [POST_NEUR_WORD_ADDR_WIDTH-1:0]     word_q, word_d;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0]          base_q, base_d;
  logic [PRE_NEUR_DATA_WIDTH-1:0]           preCnt_q, preCnt_d;
  logic                                     isPos_q, isPos_d;
  logic                                     busy_q, busy_d;
  logic                                     done_q, done_d;

  logic                                     lastRow;
  logic                                     lastWord;
  logic                                     rowEnd;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0]          sweepAddr;
  logic [WEIGHT_WIDTH-1:0]                  laneWeight [POST_NEUR_PARALLEL];
  logic [WORD_W-1:0]                        laneWord;

  assign lastRow   = (row_q == PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1));
  assign lastWord  = (word_q == POST_NEUR_WORD_ADDR_WIDTH'(ROW_WORDS - 1));
  // Row base advances by ROW_WORDS per row, so the word address is a plain add.
  assign sweepAddr = base_q + SYN_ARRAY_ADDR_WIDTH'(word_q);

  assign busy_o                = busy_q;
  assign done_o                = done_q;
  assign pre_neur_addr_o       = row_q;
  assign post_neur_word_addr_o = word_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      word_q   <= '0;
      base_q   <= '0;
      preCnt_q <= '0;
      isPos_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      word_q   <= word_d;
      base_q   <= base_d;
      preCnt_q <= preCnt_d;
      isPos_q  <= isPos_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    word_d   = word_q;
    base_d   = base_q;
    preCnt_d = preCnt_q;
    isPos_d  = isPos_q;
    done_d   = 1'b0;
    rowEnd   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (is_train_i) begin
            state_d = ST_PRE_FETCH;
            row_d   = '0;
            word_d  = '0;
            base_d  = '0;
            isPos_d = is_pos_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_PRE_FETCH: state_d = ST_PRE_CHK;
      ST_PRE_CHK: begin
        preCnt_d = pre_neur_s_cnt_i;
`ifdef SYN_ROW_SKIP_EN
        if (pre_neur_s_cnt_i == '0) begin
          rowEnd = 1'b1;
        end else begin
          state_d = ST_RD;
        end
`else
        state_d = ST_RD;
`endif
      end
      ST_RD: state_d = ST_WR;
      ST_WR: begin
        if (lastWord) begin
          rowEnd = 1'b1;
        end else begin
          word_d  = word_q + POST_NEUR_WORD_ADDR_WIDTH'(1);
          state_d = ST_RD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        row_d   = '0;
        word_d  = '0;
        base_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rowEnd) begin
      word_d = '0;
      if (lastRow) begin
        state_d = ST_FIN;
      end else begin
        row_d   = row_q + PRE_NEUR_ADDR_WIDTH'(1);
        base_d  = base_q + SYN_ARRAY_ADDR_WIDTH'(ROW_WORDS);
        state_d = ST_PRE_FETCH;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Host owns the SRAM only while idle and out of reset; sweep accesses otherwise.
  always_comb begin
    synarray_cs_o    = 1'b0;
    synarray_we_o    = 1'b0;
    synarray_addr_o  = '0;
    synarray_wdata_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (!rst_i) begin
          synarray_cs_o    = host_cs_i;
          synarray_we_o    = host_we_i;
          synarray_addr_o  = host_addr_i;
          synarray_wdata_o = host_wdata_i;
        end
      end
      ST_RD: begin
        synarray_cs_o   = 1'b1;
        synarray_addr_o = sweepAddr;
      end
      ST_WR: begin
        synarray_cs_o    = 1'b1;
        synarray_we_o    = 1'b1;
        synarray_addr_o  = sweepAddr;
        synarray_wdata_o = laneWord;
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < POST_NEUR_PARALLEL; g++) begin : g_lane
    ffstdp_lane #(
      .LR_SHIFT(LR_SHIFT)
    ) u_lane (
      .weight_i  (synarray_rdata_i[g*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .post_cnt_i(post_neur_s_cnt_i[g*POST_NEUR_SPIKE_CNT_WIDTH +: POST_NEUR_SPIKE_CNT_WIDTH]),
      .pre_cnt_i (preCnt_q),
      .is_pos_i  (isPos_q),
      .weight_o  (laneWeight[g])
    );
  end

  always_comb begin
    laneWord = '0;
    for (int l = 0; l < POST_NEUR_PARALLEL; l++) begin
      laneWord[l*WEIGHT_WIDTH +: WEIGHT_WIDTH] = laneWeight[l];
    end
  end

endmodule
